// File: rtl/logic_gates_pkg.sv
// Shared types, vector constants and the reference truth function for the
// NOT/NAND/NOR gate checker.
package logic_gates_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] VEC_00 = 2'b00;
  localparam logic [1:0] VEC_01 = 2'b01;
  localparam logic [1:0] VEC_10 = 2'b10;
  localparam logic [1:0] VEC_11 = 2'b11;

  // Returns {y2, y1, y0} = {NOR, NAND, NOT a}.
  function automatic logic [2:0] gate_expected(input logic a, input logic b);
    gate_expected = {~(a | b), ~(a & b), ~a};
  endfunction

  // Maps the per-loop step index onto the {a,b} vector driven at that step.
  function automatic logic [1:0] vec_at(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_at = VEC_00;
      2'd1:    vec_at = VEC_01;
      2'd2:    vec_at = VEC_10;
      2'd3:    vec_at = VEC_11;
      default: vec_at = VEC_00;
    endcase
  endfunction

endpackage

// File: rtl/logic_gates_model.sv
// Combinational golden model of the gate block: y0 = ~a, y1 = ~(a&b), y2 = ~(a|b).
module logic_gates_model
  import logic_gates_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y0,
  output logic y1,
  output logic y2
);

  logic [2:0] exp_s;

  assign exp_s = gate_expected(a, b);
  assign y0    = exp_s[0];
  assign y1    = exp_s[1];
  assign y2    = exp_s[2];

endmodule

// File: rtl/logic_gates_checker.sv
// Drives all four {a,b} vectors into the gate block, samples its outputs after
// a settle interval and keeps a saturating mismatch count plus first-fail capture.
module logic_gates_checker
  import logic_gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y0,
  input  logic             dut_y1,
  input  logic             dut_y2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [2:0]       fail_obs
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
  localparam logic [LOOP_W-1:0] LOOP_ONE    = LOOP_W'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE     = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = {ERR_W{1'b1}};

  state_e             state_r, state_s;
  logic [1:0]         idx_r, idx_s;
  logic [LOOP_W-1:0]  loop_r, loop_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [1:0]         vec_r, vec_s;
  logic [ERR_W-1:0]   err_r, err_s;
  logic [1:0]         fail_vec_r, fail_vec_s;
  logic [2:0]         fail_obs_r, fail_obs_s;
  logic               first_fail_r, first_fail_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               pass_r, pass_s;

  logic               exp_y0_s, exp_y1_s, exp_y2_s;
  logic [2:0]         exp_s;
  logic [2:0]         obs_s;
  logic               mismatch_s;

  logic_gates_model u_model (
    .a  (vec_r[1]),
    .b  (vec_r[0]),
    .y0 (exp_y0_s),
    .y1 (exp_y1_s),
    .y2 (exp_y2_s)
  );

  assign exp_s      = {exp_y2_s, exp_y1_s, exp_y0_s};
  assign obs_s      = {dut_y2, dut_y1, dut_y0};
  assign mismatch_s = (obs_s != exp_s);

  // Next-state and next-result computation for the run sequencer.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    loop_s       = loop_r;
    cnt_s        = cnt_r;
    vec_s        = vec_r;
    err_s        = err_r;
    fail_vec_s   = fail_vec_r;
    fail_obs_s   = fail_obs_r;
    first_fail_s = first_fail_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_s        = {ERR_W{1'b0}};
          fail_vec_s   = 2'b00;
          fail_obs_s   = 3'b000;
          first_fail_s = 1'b0;
          idx_s        = 2'd0;
          loop_s       = {LOOP_W{1'b0}};
          vec_s        = VEC_00;
          cnt_s        = {CNT_W{1'b0}};
          state_s      = ST_SETTLE;
        end else begin
          state_s = state_r;
        end
      end

      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = ST_CHECK;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_CHECK: begin
        if (mismatch_s) begin
          if (err_r != ERR_MAX) begin
            err_s = err_r + ERR_ONE;
          end else begin
            err_s = err_r;
          end
          // Only the first failure of a run is captured for the debug header.
          if (!first_fail_r) begin
            first_fail_s = 1'b1;
            fail_vec_s   = vec_r;
            fail_obs_s   = obs_s;
          end else begin
            first_fail_s = first_fail_r;
          end
        end else begin
          err_s = err_r;
        end

        if ((idx_r == 2'd3) && (loop_r == LOOP_LAST)) begin
          state_s = ST_DONE;
        end else begin
          idx_s = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            loop_s = loop_r + LOOP_ONE;
          end else begin
            loop_s = loop_r;
          end
          vec_s   = vec_at(idx_r + 2'd1);
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_SETTLE;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_SETTLE) || (state_s == ST_CHECK);
    done_s = (state_s == ST_DONE);
    pass_s = done_s && (err_s == {ERR_W{1'b0}});
  end

  // State, stimulus and result registers; status outputs are registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= 2'd0;
      loop_r       <= {LOOP_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      vec_r        <= VEC_00;
      err_r        <= {ERR_W{1'b0}};
      fail_vec_r   <= 2'b00;
      fail_obs_r   <= 3'b000;
      first_fail_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      loop_r       <= loop_s;
      cnt_r        <= cnt_s;
      vec_r        <= vec_s;
      err_r        <= err_s;
      fail_vec_r   <= fail_vec_s;
      fail_obs_r   <= fail_obs_s;
      first_fail_r <= first_fail_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
    end
  end

  assign dut_a     = vec_r[1];
  assign dut_b     = vec_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign fail_vec  = fail_vec_r;
  assign fail_obs  = fail_obs_r;

endmodule

// File: tb/tb_logic_gates_checker.sv
// Bench for logic_gates_checker: three parameterisations driven against a
// behavioural gate block with per-vector fault masks and a run-level reference model.
module tb_logic_gates_checker;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] vec;
    logic [7:0] err;
    logic [1:0] fvec;
    logic [2:0] fobs;
  } obs_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  // instance 0: defaults; 1: LOOPS=3 ERR_W=3; 2: SETTLE_CYCLES=1
  logic             start_0, start_1, start_2;
  logic             a_0, b_0, a_1, b_1, a_2, b_2;
  logic             y0_0, y1_0, y2_0, y0_1, y1_1, y2_1, y0_2, y1_2, y2_2;
  logic             busy_0, done_0, pass_0, busy_1, done_1, pass_1, busy_2, done_2, pass_2;
  logic [7:0]       err_0, err_2;
  logic [2:0]       err_1;
  logic [1:0]       fvec_0, fvec_1, fvec_2;
  logic [2:0]       fobs_0, fobs_1, fobs_2;
  logic [3:0][2:0]  mask_0, mask_1, mask_2;

  // Truth table of the gate block from plain arithmetic; returns {y2,y1,y0}.
  function automatic logic [2:0] gate_truth(input int v);
    int a;
    int b;
    a = v / 2;
    b = v % 2;
    return {1'(a + b == 0), 1'(a * b != 1), 1'(a == 0)};
  endfunction

  assign {y2_0, y1_0, y0_0} = gate_truth(int'({a_0, b_0})) ^ mask_0[{a_0, b_0}];
  assign {y2_1, y1_1, y0_1} = gate_truth(int'({a_1, b_1})) ^ mask_1[{a_1, b_1}];
  assign {y2_2, y1_2, y0_2} = gate_truth(int'({a_2, b_2})) ^ mask_2[{a_2, b_2}];

  logic_gates_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_0), .dut_a(a_0), .dut_b(b_0),
    .dut_y0(y0_0), .dut_y1(y1_0), .dut_y2(y2_0), .busy(busy_0), .done(done_0),
    .pass(pass_0), .err_count(err_0), .fail_vec(fvec_0), .fail_obs(fobs_0)
  );

  logic_gates_checker #(.SETTLE_CYCLES(4), .LOOPS(3), .ERR_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .dut_a(a_1), .dut_b(b_1),
    .dut_y0(y0_1), .dut_y1(y1_1), .dut_y2(y2_1), .busy(busy_1), .done(done_1),
    .pass(pass_1), .err_count(err_1), .fail_vec(fvec_1), .fail_obs(fobs_1)
  );

  logic_gates_checker #(.SETTLE_CYCLES(1), .LOOPS(1), .ERR_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_2), .dut_a(a_2), .dut_b(b_2),
    .dut_y0(y0_2), .dut_y1(y1_2), .dut_y2(y2_2), .busy(busy_2), .done(done_2),
    .pass(pass_2), .err_count(err_2), .fail_vec(fvec_2), .fail_obs(fobs_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t get_obs(input int inst);
    obs_t o;
    case (inst)
      0: o = '{busy_0, done_0, pass_0, {a_0, b_0}, err_0, fvec_0, fobs_0};
      1: o = '{busy_1, done_1, pass_1, {a_1, b_1}, 8'(err_1), fvec_1, fobs_1};
      default: o = '{busy_2, done_2, pass_2, {a_2, b_2}, err_2, fvec_2, fobs_2};
    endcase
    return o;
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start_0 = v;
      1: start_1 = v;
      default: start_2 = v;
    endcase
  endtask

  task automatic set_mask(input int inst, input logic [3:0][2:0] m);
    case (inst)
      0: mask_0 = m;
      1: mask_1 = m;
      default: mask_2 = m;
    endcase
  endtask

  // Run-level expectation: every faulty vector counts once per loop, saturating.
  task automatic ref_run(input logic [3:0][2:0] m, input int loops, input int errw,
                         output int e, output logic [1:0] fv, output logic [2:0] fo);
    int  raw;
    int  maxv;
    bit  found;
    raw = 0; found = 0; fv = 2'b00; fo = 3'b000;
    maxv = (1 << errw) - 1;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 4; v++) begin
        if (m[v] != 3'b000) begin
          raw++;
          if (!found) begin
            found = 1;
            fv = 2'(v);
            fo = gate_truth(v) ^ m[v];
          end
        end
      end
    end
    e = (raw > maxv) ? maxv : raw;
  endtask

  function automatic logic [3:0][2:0] y1_stuck_mask();
    logic [3:0][2:0] m;
    for (int v = 0; v < 4; v++) m[v] = gate_truth(v) & 3'b010;
    return m;
  endfunction

  // Pulses start, checks the per-cycle stimulus trace, then the final results.
  task automatic run_check(input int inst, input logic [3:0][2:0] m, input int settle,
                           input int loops, input int errw, input string name);
    obs_t       o;
    int         total;
    int         e;
    logic [1:0] fv;
    logic [2:0] fo;
    logic [1:0] ev;
    set_mask(inst, m);
    set_start(inst, 1'b1);
    step();
    set_start(inst, 1'b0);
    total = loops * 4 * (settle + 1);
    for (int k = 0; k < total; k++) begin
      o  = get_obs(inst);
      ev = 2'((k / (settle + 1)) % 4);
      checks++;
      if (o.busy !== 1'b1 || o.done !== 1'b0 || o.vec !== ev) begin
        errors++;
        $display("FAIL %s trace cyc=%0d: busy=%b done=%b vec=%b, want busy=1 done=0 vec=%b",
                 name, k, o.busy, o.done, o.vec, ev);
      end
      step();
    end
    ref_run(m, loops, errw, e, fv, fo);
    o = get_obs(inst);
    checks++;
    if ({o.busy, o.done, o.pass} !== {1'b0, 1'b1, 1'(e == 0)}) begin
      errors++;
      $display("FAIL %s status: busy/done/pass=%b%b%b, want 01%b", name, o.busy, o.done,
               o.pass, 1'(e == 0));
    end
    checks++;
    if (o.err !== 8'(e)) begin
      errors++;
      $display("FAIL %s err_count: got %0d, want %0d", name, o.err, e);
    end
    checks++;
    if (o.fvec !== fv || o.fobs !== fo) begin
      errors++;
      $display("FAIL %s capture: fail_vec=%b fail_obs=%b, want %b %b", name, o.fvec,
               o.fobs, fv, fo);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    start_0 = 1'b0; start_1 = 1'b0; start_2 = 1'b0;
    mask_0 = '0; mask_1 = '0; mask_2 = '0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      o = get_obs(i);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset inst%0d: outputs=%h, want 0", i, o);
      end
    end
    rst_n = 1'b1;
    step();
    o = get_obs(0);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL idle_hold: outputs=%h, want 0", o);
    end
  endtask

  task automatic test_clean_run();
    run_check(0, '0, 4, 1, 8, "clean_run");
  endtask

  task automatic test_y1_stuck();
    obs_t o;
    run_check(0, y1_stuck_mask(), 4, 1, 8, "y1_stuck");
    o = get_obs(0);
    checks++;
    if (o.err !== 8'd3 || o.fvec !== 2'b00 || o.fobs !== 3'b101 || o.pass !== 1'b0) begin
      errors++;
      $display("FAIL y1_stuck_const: err=%0d fvec=%b fobs=%b pass=%b, want 3 00 101 0",
               o.err, o.fvec, o.fobs, o.pass);
    end
  endtask

  task automatic test_saturation();
    obs_t o;
    run_check(1, y1_stuck_mask(), 4, 3, 3, "saturate");
    o = get_obs(1);
    checks++;
    if (o.err !== 8'd7 || o.fvec !== 2'b00 || o.fobs !== 3'b101) begin
      errors++;
      $display("FAIL saturate_const: err=%0d fvec=%b fobs=%b, want 7 00 101",
               o.err, o.fvec, o.fobs);
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t o;
    mask_0 = y1_stuck_mask();
    start_0 = 1'b1;
    step();
    start_0 = 1'b0;
    repeat (11) step();
    o = get_obs(0);
    checks++;
    if (o.vec !== 2'b10 || o.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_pos: vec=%b busy=%b, want 10 1", o.vec, o.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    o = get_obs(0);
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h, want 0", o);
    end
    step();
    rst_n = 1'b1;
    step();
    run_check(0, '0, 4, 1, 8, "after_reset");
  endtask

  task automatic test_back_to_back();
    obs_t o;
    mask_0 = y1_stuck_mask();
    start_0 = 1'b1;
    step();
    for (int k = 0; k < 63; k++) begin
      o = get_obs(0);
      checks++;
      if (o.done !== 1'(k % 21 == 20) || o.busy !== 1'(k % 21 != 20)) begin
        errors++;
        $display("FAIL b2b_done cyc=%0d: done=%b busy=%b, want done=%b", k, o.done,
                 o.busy, 1'(k % 21 == 20));
      end
      if (k % 21 == 0) begin
        checks++;
        if (o.err !== 8'd0 || o.vec !== 2'b00) begin
          errors++;
          $display("FAIL b2b_restart cyc=%0d: err=%0d vec=%b, want 0 00", k, o.err, o.vec);
        end
      end
      if (k % 21 == 20) begin
        checks++;
        if (o.err !== 8'd3) begin
          errors++;
          $display("FAIL b2b_err cyc=%0d: err=%0d, want 3", k, o.err);
        end
      end
      if (k == 62) start_0 = 1'b0;
      step();
    end
  endtask

  task automatic test_settle1();
    run_check(2, '0, 1, 1, 8, "settle1");
  endtask

  task automatic test_random();
    logic [3:0][2:0] m;
    int inst;
    for (int it = 0; it < 8; it++) begin
      inst = $urandom_range(0, 2);
      for (int v = 0; v < 4; v++) begin
        m[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      end
      repeat ($urandom_range(0, 3)) step();
      case (inst)
        0: run_check(0, m, 4, 1, 8, "random_d0");
        1: run_check(1, m, 4, 3, 3, "random_d1");
        default: run_check(2, m, 1, 1, 8, "random_d2");
      endcase
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_clean_run();
    test_y1_stuck();
    test_saturation();
    test_reset_mid_run();
    test_back_to_back();
    test_settle1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_gates_checker.md
Name: logic_gates_checker

Overview:
- Sequential stimulus driver and response checker for the combinational gate block (inputs a, b; outputs y0=NOT a, y1=NAND, y2=NOR). It is the other end of that interface: it drives a/b and reads y0..y2.
- Steps through all four {a,b} vectors, waits a settle interval, compares the observed outputs against an internal golden model, and counts mismatches.
- Sits beside the gate block on the board top level. done/pass go to LEDs; err_count and the first-fail capture go to a debug header.

Parameters:
- SETTLE_CYCLES, 4, clock cycles the driven vector is held before sampling (legal range ≥1).
- LOOPS, 1, full passes over the 4-vector set per run (legal range ≥1).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- dut_a  out  1  drives gate input a.
- dut_b  out  1  drives gate input b.
- dut_y0  in  1  observed NOT output.
- dut_y1  in  1  observed NAND output.
- dut_y2  in  1  observed NOR output.
- busy  out  1  high while in SETTLE or CHECK.
- done  out  1  high while in DONE.
- pass  out  1  high in DONE when err_count==0; otherwise 0.
- err_count  out  ERR_W  mismatches in the current/last run; saturates at all-ones.
- fail_vec  out  2  {a,b} of the first failing vector.
- fail_obs  out  3  {y2,y1,y0} observed at the first failure.

Behaviour:
- Reset (rst_n low, async): state=IDLE; dut_a=dut_b=0; busy=done=pass=0; err_count=0; fail_vec=0; fail_obs=0; vector index=0; loop count=0; settle count=0. Reset mid-run aborts immediately with no partial result.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 → clear err_count, fail_vec, fail_obs and the first-fail flag.
  - Set vector index=0, loop=0; drive {dut_a,dut_b}=2'b00; settle count=0; go to SETTLE.
  - start=0 → stay in IDLE.
- SETTLE: settle count increments each cycle. When count==SETTLE_CYCLES-1, go to CHECK. Outputs to the gate are held constant.
- CHECK (exactly one cycle):
  - Expected values: y0=~a, y1=~(a&b), y2=~(a|b), computed from the registered dut_a/dut_b.
  - Any bit differs → err_count+1, saturating at 2^ERR_W-1.
  - First mismatch of the run → capture fail_vec={a,b} and fail_obs={y2,y1,y0}; later mismatches do not overwrite the capture.
  - Next step: if index==3 and loop==LOOPS-1, go to DONE. Otherwise advance index (wraps 3→0, loop+1 on wrap), drive the new vector, clear settle count, go to SETTLE.
- DONE:
  - done=1; pass=(err_count==0); dut_a/dut_b hold the last vector; results hold.
  - start=1 restarts exactly as from IDLE (results cleared), so done is high for at least one cycle.
- start is ignored while busy; no queuing.
- Timing: vector order per loop is 00,01,10,11. Each vector takes SETTLE_CYCLES+1 cycles. done rises LOOPS*4*(SETTLE_CYCLES+1) cycles after the clock edge that accepted start (20 cycles at defaults).
- The y inputs are synchronous to clk (same-domain combinational path); no synchronizer.

Decomposition:
- Shared package logic_gates_pkg:
  - state enum;
  - vector constants (VEC_00..VEC_11);
  - function gate_expected(a,b) returning {y2,y1,y0}.
- One natural sub-module: logic_gates_model, a combinational golden model (a,b → y0,y1,y2). It is instanced in the CHECK compare path and reusable by the bench scoreboard.

Test Plan:
1. Real gate block connected, defaults, one-cycle start pulse → busy high 20 cycles; dut_a/dut_b sequence 00,01,10,11, each held 5 cycles; then done=1, pass=1, err_count=0.
2. dut_y1 forced 0, defaults → err_count=3 (vectors 00,01,10); fail_vec=2'b00; fail_obs=3'b101; pass=0.
3. LOOPS=3, ERR_W=3, dut_y1 forced 0 → 9 raw mismatches; err_count saturates at 3'd7; fail_vec/fail_obs still from the first failure (00, 101).
4. rst_n pulled low mid-settle of vector 10 → all outputs return to reset values asynchronously; after release plus a start pulse, a clean run gives pass=1 after 20 cycles.
5. start held high continuously → start re-pulses during busy have no effect; done is high for exactly 1 cycle every 21 cycles, and each run restarts at vector 00 with err_count cleared.
6. SETTLE_CYCLES=1 → each vector held 2 cycles; done 8 cycles after start; pass=1 with the real gate block.
